// File: rtl/cpu_sramlike_bridge.sv
// cpu_sramlike_bridge: merges the core's single-cycle instruction and data
// SRAM ports onto one shared SRAM-like bus (req/addr_ok/data_ok).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   inst_en/addr      fetch request; inst_rdata valid whenever stall=0
//   data_en/wen/addr  data request; data_wdata store data;
//                     data_rdata valid whenever stall=0
//   stall             to the core's stall_from_cache
//   bus_req/wr/size/addr/wdata  request side of the shared bus
//   bus_addr_ok/data_ok/rdata   slave responses
module cpu_sramlike_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAP_KSEG   = 1,
    parameter int DATA_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        B_IDLE,
        B_ADDR,
        B_DATA
    } bus_state_e;

    bus_state_e state_q, state_d;

    logic              done_i, done_d;
    logic [DATA_W-1:0] rdata_i_q, rdata_d_q;

    // Latched request; owner_q=1 means the data channel holds the bus
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;

    logic busy;
    logic pend_i, pend_d;
    logic issue, issue_data, complete;

    // kseg0/kseg1 (addr[31:30]==2'b10) fold onto the low 512 MiB
    function automatic logic [ADDR_W-1:0] kseg_map(
        input logic [ADDR_W-1:0] a
    );
        logic [ADDR_W-1:0] p;
        p = a;
        if (MAP_KSEG != 0 && a[31:30] == 2'b10) begin
            p[ADDR_W-1:29] = '0;
        end
        return p;
    endfunction

    // Illegal enable patterns fall back to a word access
    function automatic logic [1:0] wen_size(input logic [3:0] wen);
        logic [1:0] s;
        case (wen)
            4'b0001, 4'b0010,
            4'b0100, 4'b1000: s = 2'd0;
            4'b0011, 4'b1100: s = 2'd1;
            default:          s = 2'd2;
        endcase
        return s;
    endfunction

    // Depends on inputs and registers only, never on the bus handshake
    assign stall = (inst_en & ~done_i) | (data_en & ~done_d);

    assign busy   = (state_q != B_IDLE);
    assign pend_i = inst_en & ~done_i & ~(busy & ~owner_q);
    assign pend_d = data_en & ~done_d & ~(busy & owner_q);

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_data = 1'b0;
        complete   = 1'b0;
        unique case (state_q)
            B_IDLE: begin
                if (pend_i | pend_d) begin
                    issue      = 1'b1;
                    issue_data = (DATA_FIRST != 0) ? pend_d : ~pend_i;
                    state_d    = B_ADDR;
                end
            end
            B_ADDR: begin
                if (bus_addr_ok) begin
                    state_d = B_DATA;
                end
            end
            B_DATA: begin
                if (bus_data_ok) begin
                    complete = 1'b1;
                    // Hand the bus straight to the other channel
                    if (owner_q ? pend_i : pend_d) begin
                        issue      = 1'b1;
                        issue_data = ~owner_q;
                        state_d    = B_ADDR;
                    end else begin
                        state_d = B_IDLE;
                    end
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= B_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wdata_q <= '0;
        end else if (issue) begin
            owner_q <= issue_data;
            if (issue_data) begin
                addr_q  <= kseg_map(data_addr);
                wr_q    <= |data_wen;
                size_q  <= wen_size(data_wen);
                wdata_q <= data_wdata;
            end else begin
                addr_q  <= kseg_map(inst_addr);
                wr_q    <= 1'b0;
                size_q  <= 2'd2;
                wdata_q <= '0;
            end
        end
    end

    // A completion on the step-closing edge belongs to a withdrawn
    // request, so the clear takes priority over setting the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_i <= 1'b0;
            done_d <= 1'b0;
        end else if (!stall) begin
            done_i <= 1'b0;
            done_d <= 1'b0;
        end else if (complete) begin
            if (owner_q) begin
                done_d <= 1'b1;
            end else begin
                done_i <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_i_q <= '0;
            rdata_d_q <= '0;
        end else if (complete && !wr_q) begin
            if (owner_q) begin
                rdata_d_q <= bus_rdata;
            end else begin
                rdata_i_q <= bus_rdata;
            end
        end
    end

    assign inst_rdata = rdata_i_q;
    assign data_rdata = rdata_d_q;
    assign bus_req    = (state_q == B_ADDR);
    assign bus_wr     = wr_q;
    assign bus_size   = size_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;

endmodule

// File: doc/cpu_sramlike_bridge.md
Name: cpu_sramlike_bridge

Overview:
- Parametrised successor to the CPU-top memory glue. Converts the core's two single-cycle SRAM-style ports (instruction, data) into one shared SRAM-like handshake bus (req/addr_ok/data_ok).
- Generalises the fixed data-address remap into configurable kseg0/kseg1 translation on both channels.
- Generates the core's stall_from_cache and holds read data until the whole pipeline step has completed.
- Sits between the mips top and the cache/AXI bridge.

Parameters:
- ADDR_W, 32, address width on both sides; must be ≥ 32.
- DATA_W, 32, data width; byte-enable width is DATA_W/8; fixed at 32 in this revision.
- MAP_KSEG, 1, when 1: an address with addr[31:30]==2'b10 maps to {3'b000, addr[28:0]}; when 0: passthrough.
- DATA_FIRST, 1, when 1 the data channel wins arbitration; when 0 the instruction channel wins.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- inst_en  in  1  instruction fetch request
- inst_addr  in  ADDR_W  fetch virtual address
- inst_rdata  out  DATA_W  fetch data; valid in any cycle with stall=0
- data_en  in  1  data access request
- data_wen  in  4  byte write enables; 0 means read
- data_addr  in  ADDR_W  data virtual address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data; valid in any cycle with stall=0
- stall  out  1  to core stall_from_cache
- bus_req  out  1  bus request
- bus_wr  out  1  1 for write
- bus_size  out  2  0 byte, 1 half, 2 word
- bus_addr  out  ADDR_W  physical address
- bus_wdata  out  DATA_W  write data
- bus_addr_ok  in  1  address accepted
- bus_data_ok  in  1  data returned or write done
- bus_rdata  in  DATA_W  read data

Behaviour:
- Per-channel registers: done_i, done_d, rdata_i_q, rdata_d_q.
- stall = (inst_en & ~done_i) | (data_en & ~done_d). This is combinational from inputs and registers only, with no loop through bus inputs.
- Step completion: on a clock edge with stall==0, clear done_i and done_d. The core advances on that same edge.
- A channel is pending when en=1 and done=0, and it is not the channel currently in flight.

Bus FSM, states B_IDLE, B_ADDR, B_DATA:
- B_IDLE: if any channel is pending, latch the winner (per DATA_FIRST), latch addr/wr/size/wdata, and go to B_ADDR.
- B_ADDR: bus_req=1 with latched fields driven. On addr_ok, go to B_DATA.
- B_DATA: bus_req=0. data_ok is sampled only here; the slave guarantees at least 1 cycle after addr_ok.
- On data_ok: set the owner's done flag, capture bus_rdata into the owner's rdata_q (reads only), then:
  - if the other channel is pending, latch it and go directly to B_ADDR;
  - otherwise go to B_IDLE.

Request attributes:
- bus_size from wen: 4'b0000→2 (read word); 1111→2; 0011/1100→1; one-hot→0. Other patterns are illegal: treat as 2.
- bus_wr = |data_wen. Instruction channel: always a word read.
- Outputs take their values from latched registers, so they stay stable while in B_ADDR even if the core's inputs change.

Timing:
- Latency with a zero-wait slave: single access has stall high for 3 cycles, released in cycle 3.
- Both channels: the second request issues back-to-back; release in cycle 5.

Boundary rules:
- en dropped mid-transaction: the transaction completes and its data is stored, but the done flag is ignored by stall.
- en=1 with done=1 and stall=0: treated as a new request only after the clearing edge.
- Both en=0: stall=0 and the FSM stays idle.
- rdata_q holds its value until overwritten and is never cleared by step completion.

Reset (asynchronous, any time including mid-transaction):
- FSM goes to B_IDLE; done flags, rdata_q, and latched fields go to 0.
- bus_req=0. stall is then recomputed from en.
- The bus slave is reset on the same rst.

Test Plan:
- Reset check: rst pulse with bus_req=1 in B_ADDR → next cycle bus_req=0; stall=inst_en; inst_rdata=0 and data_rdata=0.
- Fetch only, zero-wait slave: inst_en=1, inst_addr=0xBFC00000 → bus_addr=0x1FC00000, size=2, wr=0. Stall=1 for cycles 0–2, stall=0 in cycle 3 with inst_rdata=bus_rdata (0x24080001).
- Dual request, DATA_FIRST=1: store wen=0011 at 0x80001002 plus fetch → first bus_req carries addr 0x00001002, size=1, wr=1; second carries the fetch; stall released in cycle 5.
- Wait states: addr_ok delayed 4 cycles and data_ok delayed 3 → bus_addr/bus_wdata stable throughout; stall released exactly 1 cycle after data_ok.
- MAP_KSEG=0 and user address: data read at 0x00400000 with MAP_KSEG=0 → bus_addr=0x00400000. Address 0x7FFF0000 with MAP_KSEG=1 → unchanged.
- Withdrawn request: inst_en dropped during B_DATA → transaction completes, stall=0 in that cycle, and no further bus_req is issued.
